hdmi_period_scheduler: RTL and testbench
========================================

# hdmi_period_scheduler

Per-pixel-clock period sequencer for the HDMI transmit path, in the `clk_pixel` domain. It decides, for every pixel slot, whether the TMDS encoders feeding the 10:1 serializer emit control, video preamble/guard/data, or data-island preamble/guard/data symbols. It arbitrates a single data-island requester into horizontal and vertical blanking without violating video timing. It also generates the serializer reset sequence.

## Interface
- SCREEN_WIDTH, 640: active pixels per line.
- SCREEN_HEIGHT, 480: active lines per frame.
- FRAME_WIDTH, 800: total pixels per line (cx wraps FRAME_WIDTH-1 -> 0).
- FRAME_HEIGHT, 525: total lines per frame.
- MAX_PACKETS, 18: largest island length, in 32-cycle packets.
- MIN_GAP, 4: minimum CTRL cycles before an island, and minimum slack after it.
- RESET_HOLD, 4: `clk_pixel` cycles `ser_reset` stays high after `reset` falls.
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- cx  in  $clog2(FRAME_WIDTH)  current pixel column from the video timing generator.
- cy  in  $clog2(FRAME_HEIGHT)  current line.
- island_req  in  1  level request for one data island.
- island_packets  in  5  packet count N; valid for 1..MAX_PACKETS, sampled at grant.
- mode  out  3  slot type: 0 CTRL, 1 VID_PRE, 2 VID_GB, 3 VID, 4 ISL_PRE, 5 ISL_GB_LEAD, 6 ISL_DATA, 7 ISL_GB_TRAIL.
- ctl  out  4  CTL3..CTL0 for the encoders.
- island_grant  out  1  one-cycle pulse.
- pkt_next  out  1  one-cycle pulse at the start of each packet.
- pkt_index  out  5  packet number inside the island.
- pkt_pixel  out  5  cycle within the packet, 0..31.
- island_abort  out  1  one-cycle pulse when an island is truncated.
- ser_reset  out  1  reset to the serializer.

## Operation
- Video slots: VID when cx<SCREEN_WIDTH and cy<SCREEN_HEIGHT.
- next_active = (cy<SCREEN_HEIGHT-1) or (cy==FRAME_HEIGHT-1).
- On next_active lines: VID_PRE for cx in FRAME_WIDTH-10..FRAME_WIDTH-3, then VID_GB for FRAME_WIDTH-2..FRAME_WIDTH-1.
- Video modes are computed directly from cx/cy every cycle and always win over an island.
- Budget D = P-cx.
  - P = FRAME_WIDTH-10 if next_active.
  - P = FRAME_WIDTH otherwise.
  - Islands never cross the line end.
- ctrl_run: saturating count of consecutive CTRL output slots. It carries across line wrap and resets on any non-CTRL slot.
- Island FSM states: IDLE -> PRE (8 cycles) -> GB_LEAD (2) -> DATA (32*N) -> GB_TRAIL (2) -> IDLE.
- Grant condition, evaluated in IDLE for the slot being decided, with all of the following true:
  - the slot would otherwise be CTRL;
  - island_req=1;
  - 1<=island_packets<=MAX_PACKETS;
  - ctrl_run>=MIN_GAP;
  - D >= 12+32*N+MIN_GAP.
- On grant: latch N, enter PRE, and pulse island_grant in the first ISL_PRE slot.
- island_req changes after grant are ignored. A request held across the trailing guard band is re-arbitrated only after MIN_GAP further CTRL slots.
- In DATA:
  - pkt_pixel counts 0..31, then wraps and increments pkt_index;
  - pkt_next=1 when pkt_pixel==0.
- ctl output: 4'b0001 in VID_PRE, 4'b0101 in ISL_PRE, 4'b0000 otherwise.
- Abort: if a video mode slot is reached while the FSM is not IDLE (cx/cy discontinuity), the FSM returns to IDLE, that slot shows the video mode, and island_abort pulses.
- Serializer reset and hold:
  - ser_reset=1 while reset is asserted and for RESET_HOLD rising edges after release.
  - While ser_reset=1, mode is forced to CTRL, no grant occurs, and ctrl_run is held at 0.

## Timing
- Latency is 1: cx/cy sampled at edge k produce mode/ctl/pkt outputs for that pixel after edge k.
- All outputs are registered.
- Reset values:
  - mode=0, ctl=0, island_grant=0, pkt_next=0, pkt_index=0, pkt_pixel=0, island_abort=0;
  - ser_reset=1, FSM=IDLE, ctrl_run=0.
- Reset asserted mid-island clears the FSM immediately (asynchronous). No abort pulse is generated.
- When grant and a video-mode slot would coincide, video wins and there is no grant. This cannot occur when D is honoured.
- island_packets=0 or >MAX_PACKETS: the request is treated as absent and no grant is given.

## Test plan
- Reset release: ser_reset stays 1 for exactly 4 edges after release, with mode=0 throughout. Then line cy=0 gives mode=3 for cx 0..639 and mode=0 for cx 640..789.
- Preamble on active line: cy=0 gives mode=1, ctl=0001 at cx 790..797, then mode=2 at cx 798..799. cy=479 gives mode=0 there; cy=524 gives the preamble.
- Island N=1 requested from cy=0, cx=640:
  - grant and ISL_PRE at cx 644..651 (ctl=0101);
  - GB_LEAD at 652..653;
  - DATA at 654..685 with pkt_next at 654;
  - GB_TRAIL at 686..687;
  - CTRL from 688.
- Late request N=1 at cy=0, cx=750 (D=40<48): no grant on this line. Grant at cy=1, cx=644.
- N=18 on an active line is never granted. Held into vblank (cy=480), it is granted once ctrl_run>=4. During DATA, pkt_pixel/pkt_index/pkt_next step as specified, with pkt_index 0..17 and pkt_next on each packet's first slot.
- Abort: an island in DATA when cx is forced to 0 with cy=0 gives mode=3 in that slot, island_abort=1 for one cycle, and the FSM returns to IDLE. island_packets=0 gives no grant.

Source files
------------

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: per-pixel-slot period sequencer for the HDMI transmit path.
// Chooses control, video preamble/guard/data or data-island symbols for every pixel
// slot, fits one data island into blanking, and sequences the serializer reset.
module hdmi_period_scheduler #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FRAME_WIDTH   = 800,
    parameter int FRAME_HEIGHT  = 525,
    parameter int MAX_PACKETS   = 18,
    parameter int MIN_GAP       = 4,
    parameter int RESET_HOLD    = 4
) (
    input  logic                            clk_pixel,
    input  logic                            reset,
    input  logic [$clog2(FRAME_WIDTH)-1:0]  cx,
    input  logic [$clog2(FRAME_HEIGHT)-1:0] cy,
    input  logic                            island_req,
    input  logic [4:0]                      island_packets,
    output logic [2:0]                      mode,
    output logic [3:0]                      ctl,
    output logic                            island_grant,
    output logic                            pkt_next,
    output logic [4:0]                      pkt_index,
    output logic [4:0]                      pkt_pixel,
    output logic                            island_abort,
    output logic                            ser_reset
);
    localparam int CXW   = $clog2(FRAME_WIDTH);
    localparam int CYW   = $clog2(FRAME_HEIGHT);
    localparam int RUNW  = $clog2(MIN_GAP + 1);
    localparam int HOLDW = $clog2(RESET_HOLD + 1);

    localparam logic [CXW-1:0]   CX_ACTIVE_END  = CXW'(SCREEN_WIDTH);
    localparam logic [CXW-1:0]   CX_PRE_START   = CXW'(FRAME_WIDTH - 10);
    localparam logic [CXW-1:0]   CX_GB_START    = CXW'(FRAME_WIDTH - 2);
    localparam logic [CYW-1:0]   CY_ACTIVE_END  = CYW'(SCREEN_HEIGHT);
    localparam logic [CYW-1:0]   CY_LAST_ACTIVE = CYW'(SCREEN_HEIGHT - 1);
    localparam logic [CYW-1:0]   CY_LAST        = CYW'(FRAME_HEIGHT - 1);
    localparam logic [RUNW-1:0]  RUN_SAT        = RUNW'(MIN_GAP);
    localparam logic [HOLDW-1:0] HOLD_DONE      = HOLDW'(RESET_HOLD);
    localparam logic [4:0]       PKT_MAX        = 5'(MAX_PACKETS);

    typedef enum logic [2:0] {
        M_CTRL         = 3'd0,
        M_VID_PRE      = 3'd1,
        M_VID_GB       = 3'd2,
        M_VID          = 3'd3,
        M_ISL_PRE      = 3'd4,
        M_ISL_GB_LEAD  = 3'd5,
        M_ISL_DATA     = 3'd6,
        M_ISL_GB_TRAIL = 3'd7
    } mode_t;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_GB_LEAD, S_DATA, S_GB_TRAIL} state_t;

    // Island phase the *next* slot belongs to; cnt_q is the position inside that phase.
    state_t           state_q, state_n;
    logic [9:0]       cnt_q, cnt_n;
    logic [4:0]       n_q, n_n;
    logic [RUNW-1:0]  ctrl_run_q, ctrl_run_n;
    logic [HOLDW-1:0] hold_q;

    logic       ser_next, next_active, grant_ok, data_last;
    mode_t      video_mode, mode_n;
    logic [3:0] ctl_n;
    logic       grant_n, abort_n, pkt_next_n;
    logic [4:0] pkt_index_n, pkt_pixel_n;
    int         budget, need;

    // ser_reset stays high until RESET_HOLD edges have passed since reset release.
    assign ser_next  = (hold_q != HOLD_DONE);
    assign data_last = (cnt_q[9:5] == n_q - 5'd1) && (cnt_q[4:0] == 5'd31);

    // Video timing decoded straight from cx/cy; it always takes precedence.
    always_comb begin
        next_active = (cy < CY_LAST_ACTIVE) || (cy == CY_LAST);
        video_mode  = M_CTRL;
        if ((cy < CY_ACTIVE_END) && (cx < CX_ACTIVE_END))
            video_mode = M_VID;
        else if (next_active && (cx >= CX_GB_START))
            video_mode = M_VID_GB;
        else if (next_active && (cx >= CX_PRE_START))
            video_mode = M_VID_PRE;
    end

    // Admission test: the whole island plus trailing slack must fit before the line's next video period.
    always_comb begin
        budget   = (next_active ? FRAME_WIDTH - 10 : FRAME_WIDTH) - int'(cx);
        need     = 12 + 32 * int'(island_packets) + MIN_GAP;
        grant_ok = island_req && (island_packets != 5'd0) && (island_packets <= PKT_MAX)
                   && (ctrl_run_q >= RUN_SAT) && (budget >= need);
    end

    // Island sequencer: decides the mode of the slot at cx/cy and the phase of the following slot.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
        state_n     = state_q;
        cnt_n       = cnt_q;
        n_n         = n_q;
        mode_n      = M_CTRL;
        grant_n     = 1'b0;
        abort_n     = 1'b0;
        pkt_next_n  = 1'b0;
        pkt_index_n = '0;
        pkt_pixel_n = '0;
        if (ser_next) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else if (video_mode != M_CTRL) begin
            // A video slot inside an island means cx/cy jumped: drop the island.
            mode_n  = video_mode;
            abort_n = (state_q != S_IDLE);
            state_n = S_IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant_ok) begin
                        mode_n  = M_ISL_PRE;
                        grant_n = 1'b1;
                        n_n     = island_packets;
                        state_n = S_PRE;
                        cnt_n   = 10'd1;
                    end
                end
                S_PRE: begin
                    mode_n = M_ISL_PRE;
                    if (cnt_q == 10'd7) begin
                        state_n = S_GB_LEAD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 10'd1;
                    end
                end
                S_GB_LEAD: begin
                    mode_n = M_ISL_GB_LEAD;
                    if (cnt_q == 10'd1) begin
                        state_n = S_DATA;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 10'd1;
                    end
                end
                S_DATA: begin
                    mode_n      = M_ISL_DATA;
                    pkt_pixel_n = cnt_q[4:0];
                    pkt_index_n = cnt_q[9:5];
                    pkt_next_n  = (cnt_q[4:0] == 5'd0);
                    if (data_last) begin
                        state_n = S_GB_TRAIL;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 10'd1;
                    end
                end
                S_GB_TRAIL: begin
                    mode_n = M_ISL_GB_TRAIL;
                    if (cnt_q == 10'd1) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 10'd1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        ctl_n = 4'b0000;
        if (mode_n == M_VID_PRE)
            ctl_n = 4'b0001;
        else if (mode_n == M_ISL_PRE)
            ctl_n = 4'b0101;

        // Saturating run of CTRL slots; it survives line wrap and clears on anything else.
        if (ser_next || (mode_n != M_CTRL))
            ctrl_run_n = '0;
        else if (ctrl_run_q == RUN_SAT)
            ctrl_run_n = ctrl_run_q;
        else
            ctrl_run_n = ctrl_run_q + RUNW'(1);
    end

    // Serializer reset stretcher.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            ser_reset <= 1'b1;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
            if (hold_q != HOLD_DONE)
                hold_q <= hold_q + HOLDW'(1);
            ser_reset <= ser_next;
        end
    end

    // Island FSM and CTRL-run state register.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            ctrl_run_q <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            n_q        <= n_n;
            ctrl_run_q <= ctrl_run_n;
        end
    end

    // Registered slot outputs, one cycle after cx/cy are sampled.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            mode         <= M_CTRL;
            ctl          <= 4'b0000;
            island_grant <= 1'b0;
            pkt_next     <= 1'b0;
            pkt_index    <= '0;
            pkt_pixel    <= '0;
            island_abort <= 1'b0;
        end else begin
            mode         <= mode_n;
            ctl          <= ctl_n;
            island_grant <= grant_n;
            pkt_next     <= pkt_next_n;
            pkt_index    <= pkt_index_n;
            pkt_pixel    <= pkt_pixel_n;
            island_abort <= abort_n;
        end
    end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler: directed stimulus with a slot-offset island model and literal spot checks.
module tb_hdmi_period_scheduler;
    localparam int SW = 640, SH = 480, FW = 800, FH = 525;
    localparam int MAXP = 18, GAP = 4, HOLD = 4;

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] cx = '0;
    logic [9:0] cy = '0;
    logic       island_req = 1'b0;
    logic [4:0] island_packets = '0;
    logic [2:0] mode;
    logic [3:0] ctl;
    logic       island_grant, pkt_next, island_abort, ser_reset;
    logic [4:0] pkt_index, pkt_pixel;

    int tests = 0;
    int fails = 0;
    bit drv_reset = 1'b1;
    bit drv_req = 1'b0;
    int drv_pkts = 0;
    int grants = 0;
    int grant_cx = -1;
    int grant_cy = -1;

    hdmi_period_scheduler dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .cx             (cx),
        .cy             (cy),
        .island_req     (island_req),
        .island_packets (island_packets),
        .mode           (mode),
        .ctl            (ctl),
        .island_grant   (island_grant),
        .pkt_next       (pkt_next),
        .pkt_index      (pkt_index),
        .pkt_pixel      (pkt_pixel),
        .island_abort   (island_abort),
        .ser_reset      (ser_reset)
    );

    initial forever #5 clk_pixel = ~clk_pixel;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cx=%0d cy=%0d t=%0t)", name, got, want, cx, cy, $time);
        end
    endtask

    // Reference model: island described by its slot offset k from the grant slot.
    initial begin : model
        int edges, k, n, run, j, m, p_end, vm;
        bit act, ser_on;
        bit e_grant, e_abort, e_next;
        int e_idx, e_pix;
        edges = 0; k = 0; n = 0; run = 0; act = 0;
        forever begin
            @(posedge clk_pixel);
            #1;
            e_grant = 0; e_abort = 0; e_next = 0; e_idx = 0; e_pix = 0; m = 0;
            if (reset) begin
                edges = 0; act = 0; run = 0;
                check("reset ser_reset", ser_reset, 1);
            end else begin
                ser_on = (edges < HOLD);
                if (edges < HOLD) edges++;
                vm = 0;
                if (cy < SH && cx < SW) vm = 3;
                else if ((cy < SH - 1 || cy == FH - 1) && cx >= FW - 10) vm = (cx >= FW - 2) ? 2 : 1;
                p_end = (cy < SH - 1 || cy == FH - 1) ? FW - 10 : FW;
                if (ser_on) begin
                    act = 0;
                end else if (vm != 0) begin
                    m = vm; e_abort = act; act = 0;
                end else begin
                    if (!act && island_req && island_packets >= 1 && island_packets <= MAXP && run >= GAP
                        && (p_end - int'(cx)) >= 12 + 32 * int'(island_packets) + GAP) begin
                        act = 1; k = 0; n = int'(island_packets); e_grant = 1;
                    end
                    if (act) begin
                        if (k < 8) m = 4;
                        else if (k < 10) m = 5;
                        else if (k < 10 + 32 * n) begin
                            m = 6; j = k - 10;
                            e_pix = j % 32; e_idx = j / 32; e_next = (e_pix == 0);
                        end else m = 7;
                        k++;
                        if (k == 12 + 32 * n) act = 0;
                    end
                end
                if (ser_on || m != 0) run = 0;
                else if (run < 100000) run++;
                check("model ser_reset", ser_reset, ser_on ? 1 : 0);
            end
            check("model mode", mode, m);
            check("model ctl", ctl, (m == 1) ? 1 : (m == 4) ? 5 : 0);
            check("model island_grant", island_grant, e_grant);
            check("model island_abort", island_abort, e_abort);
            check("model pkt_next", pkt_next, e_next);
            check("model pkt_index", pkt_index, e_idx);
            check("model pkt_pixel", pkt_pixel, e_pix);
        end
    end

    // One pixel slot: inputs change on the falling edge, outputs are read 2 time units after the rising edge.
    task automatic tick(input int x, input int y);
        @(negedge clk_pixel);
        cx = 10'(x);
        cy = 10'(y);
        island_req = drv_req;
        island_packets = 5'(drv_pkts);
        reset = drv_reset;
        @(posedge clk_pixel);
        #2;
        if (island_grant) begin
            grants++;
            grant_cx = x;
            grant_cy = y;
        end
    endtask

    task automatic run_line(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) tick(x, y);
    endtask

    initial begin : stimulus
        #1 reset = 1'b1;
        #1;
        check("async reset mode", mode, 0);
        check("async reset ser_reset", ser_reset, 1);

        // Reset release on the last line: preamble slots are forced to CTRL until ser_reset drops.
        cx = 10'd790; cy = 10'd524;
        tick(790, 524);
        tick(790, 524);
        drv_reset = 1'b0;
        for (int x = 790; x <= 794; x++) begin
            tick(x, 524);
            if (x < 794) begin
                check("hold ser_reset", ser_reset, 1);
                check("hold mode", mode, 0);
            end else begin
                check("release ser_reset", ser_reset, 0);
                check("cy524 preamble mode", mode, 1);
                check("cy524 preamble ctl", ctl, 1);
            end
        end
        run_line(524, 795, 799);

        // N=1 island requested at cx=640 of an active line.
        run_line(0, 0, 639);
        check("cy0 last video", mode, 3);
        drv_req = 1'b1; drv_pkts = 1; grants = 0;
        for (int x = 640; x <= 799; x++) begin
            if (x == 646) drv_req = 1'b0;
            tick(x, 0);
            case (x)
                640: check("B ctrl 640", mode, 0);
                644: begin
                    check("B grant", island_grant, 1);
                    check("B pre mode", mode, 4);
                    check("B pre ctl", ctl, 5);
                end
                651: check("B pre end", mode, 4);
                652: check("B gb lead", mode, 5);
                654: begin
                    check("B data start", mode, 6);
                    check("B pkt_next", pkt_next, 1);
                end
                685: check("B data pix31", pkt_pixel, 31);
                686: check("B gb trail", mode, 7);
                688: check("B ctrl after", mode, 0);
                790: check("B vid pre ctl", ctl, 1);
                798: check("B vid gb", mode, 2);
                default: ;
            endcase
        end
        check("B grant count", grants, 1);

        // Late request: D=40 is short of 48, so the grant moves to the next line.
        drv_req = 1'b0; grants = 0;
        run_line(0, 0, 749);
        drv_req = 1'b1; drv_pkts = 1;
        run_line(0, 750, 799);
        check("C no late grant", grants, 0);
        run_line(1, 0, 649);
        check("C grant count", grants, 1);
        check("C grant cx", grant_cx, 644);
        drv_req = 1'b0;
        run_line(1, 650, 799);

        // N=18 fits only into vertical blanking.
        drv_req = 1'b1; drv_pkts = 18; grants = 0;
        run_line(478, 640, 799);
        run_line(479, 0, 794);
        check("cy479 no preamble", mode, 0);
        run_line(479, 795, 799);
        check("D no active grant", grants, 0);
        for (int x = 0; x <= 799; x++) begin
            tick(x, 480);
            case (x)
                0: begin
                    check("D grant", island_grant, 1);
                    check("D pre mode", mode, 4);
                end
                10: begin
                    check("D pkt0 next", pkt_next, 1);
                    check("D pkt0 index", pkt_index, 0);
                end
                42: begin
                    check("D pkt1 next", pkt_next, 1);
                    check("D pkt1 index", pkt_index, 1);
                end
                43: begin
                    check("D pkt1 mid next", pkt_next, 0);
                    check("D pkt1 pixel", pkt_pixel, 1);
                end
                585: begin
                    check("D last index", pkt_index, 17);
                    check("D last pixel", pkt_pixel, 31);
                end
                586: check("D gb trail", mode, 7);
                588: check("D ctrl after", mode, 0);
                default: ;
            endcase
        end
        check("D grant count", grants, 1);
        check("D grant cy", grant_cy, 480);

        // Abort: cx jumps back to 0 while the island is in DATA.
        drv_req = 1'b0; grants = 0;
        run_line(0, 630, 639);
        drv_req = 1'b1; drv_pkts = 2;
        for (int x = 640; x <= 710; x++) begin
            if (x == 650) drv_req = 1'b0;
            tick(x, 0);
        end
        check("E in data", mode, 6);
        tick(0, 0);
        check("E abort mode", mode, 3);
        check("E abort pulse", island_abort, 1);
        check("E abort pkt_next", pkt_next, 0);
        tick(1, 0);
        check("E abort one cycle", island_abort, 0);
        run_line(0, 2, 639);
        drv_req = 1'b1; drv_pkts = 0; grants = 0;
        run_line(0, 640, 789);
        check("E pkts0 no grant", grants, 0);
        drv_pkts = 19;
        run_line(490, 0, 40);
        check("E pkts19 no grant", grants, 0);

        // Reset during DATA: async clear, no abort, then regrant after the hold and MIN_GAP.
        drv_req = 1'b0;
        run_line(0, 630, 639);
        drv_req = 1'b1; drv_pkts = 1; grants = 0;
        run_line(0, 640, 655);
        check("F in data", mode, 6);
        #1 reset = 1'b1; drv_reset = 1'b1;
        #1;
        check("F async mode", mode, 0);
        check("F async abort", island_abort, 0);
        check("F async ser_reset", ser_reset, 1);
        check("F async pkt_pixel", pkt_pixel, 0);
        tick(656, 0);
        tick(657, 0);
        drv_reset = 1'b0; grants = 0;
        for (int x = 658; x <= 720; x++) begin
            tick(x, 0);
            if (x == 661) check("F hold edge4", ser_reset, 1);
            if (x == 662) check("F hold done", ser_reset, 0);
        end
        check("F grant count", grants, 2);
        check("F regrant cx", grant_cx, 714);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
